// File: rtl/ccff_chain_loader_if.sv
// Bitstream word stream into the CCFF chain loader (valid/ready, MSB shifted first).
interface ccff_chain_loader_if #(
  parameter int unsigned DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/ccff_chain_loader.sv
// Serial configuration-chain loader: fetches bitstream words, shifts exactly CHAIN_LEN bits into
// ccff_head, then optionally recirculates the chain once and compares CRC-16-CCITT signatures.
module ccff_chain_loader #(
  parameter int unsigned CHAIN_LEN = 1024,
  parameter int unsigned DATA_W    = 8,
  parameter bit          VERIFY_EN = 1'b1
) (
  input  logic                prog_clk,
  input  logic                prog_reset_n,
  input  logic                start,
  input  logic                abort,
  ccff_chain_loader_if.slave  bs,
  output logic                ccff_head,
  output logic                ccff_shift_en,
  input  logic                ccff_tail,
  output logic                busy,
  output logic                done,
  output logic                crc_ok
);

  localparam int unsigned CntW  = $clog2(CHAIN_LEN);
  localparam int unsigned WordW = $clog2(DATA_W);
  localparam logic [CntW-1:0]  LastBit     = CntW'(CHAIN_LEN - 1);
  localparam logic [WordW-1:0] LastWordBit = WordW'(DATA_W - 1);
  localparam logic [15:0]      CrcInit     = 16'hFFFF;
  localparam logic [15:0]      CrcPoly     = 16'h1021;

  typedef enum logic [2:0] {StIdle, StFetch, StShift, StVerify, StDone} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sreg_q;
  logic [CntW-1:0]   bit_cnt_q;
  logic [WordW-1:0]  word_cnt_q;
  logic [15:0]       crc_l_q, crc_v_q, crc_v_next;
  logic              in_ready_q, shift_en_q, busy_q, done_q, crc_ok_q;
  logic              last_bit, last_word_bit;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CrcPoly : 16'h0000);
  endfunction

  assign last_bit      = (bit_cnt_q == LastBit);
  assign last_word_bit = (word_cnt_q == LastWordBit);
  assign crc_v_next    = crc16_step(crc_v_q, ccff_tail);

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: if (start) state_d = StFetch;
        StFetch:        if (bs.in_valid) state_d = StShift;
        StShift: begin
          if (last_bit) begin
            state_d = VERIFY_EN ? StVerify : StDone;
          end else if (last_word_bit) begin
            state_d = StFetch;
          end
        end
        StVerify:       if (last_bit) state_d = StDone;
        default:        state_d = StIdle;
      endcase
    end
  end

  // Head is combinational so the recirculate path is a straight wire from tail in VERIFY.
  always_comb begin
    ccff_head = 1'b0;
    case (state_q)
      StShift:  ccff_head = sreg_q[DATA_W-1];
      StVerify: ccff_head = ccff_tail;
      default:  ccff_head = 1'b0;
    endcase
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q    <= StIdle;
      sreg_q     <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      crc_l_q    <= CrcInit;
      crc_v_q    <= CrcInit;
      in_ready_q <= 1'b0;
      shift_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      crc_ok_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      // Output flags follow the next state so they line up with state_q without a decode stage.
      in_ready_q <= (state_d == StFetch);
      shift_en_q <= (state_d == StShift) || (state_d == StVerify);
      busy_q     <= (state_d == StFetch) || (state_d == StShift) || (state_d == StVerify);
      done_q     <= (state_d == StDone);
      if (abort) begin
        bit_cnt_q <= '0;
        crc_ok_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle, StDone: begin
            if (start) begin
              bit_cnt_q <= '0;
              crc_l_q   <= CrcInit;
              crc_v_q   <= CrcInit;
              crc_ok_q  <= 1'b0;
            end
          end
          StFetch: begin
            if (bs.in_valid) begin
              sreg_q     <= bs.in_data;
              word_cnt_q <= '0;
            end
          end
          StShift: begin
            sreg_q     <= sreg_q << 1;
            word_cnt_q <= word_cnt_q + 1'b1;
            crc_l_q    <= crc16_step(crc_l_q, sreg_q[DATA_W-1]);
            if (last_bit) begin
              bit_cnt_q <= '0;
              if (!VERIFY_EN) crc_ok_q <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
          StVerify: begin
            crc_v_q <= crc_v_next;
            if (last_bit) begin
              bit_cnt_q <= '0;
              // Compare including the final recirculated bit.
              crc_ok_q  <= (crc_v_next == crc_l_q);
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bs.in_ready   = in_ready_q;
  assign ccff_shift_en = shift_en_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign crc_ok        = crc_ok_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: two instances (verify on / off) each driving a behavioural chain.
module tb_ccff_chain_loader;

  localparam int unsigned NA = 37;
  localparam int unsigned NB = 16;
  localparam int unsigned W  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  // Instance A: CHAIN_LEN=37 with verify pass.
  logic start_a, abort_a, head_a, sen_a, tail_a, busy_a, done_a, ok_a;
  ccff_chain_loader_if #(.DATA_W(W)) bs_a ();
  ccff_chain_loader #(.CHAIN_LEN(NA), .DATA_W(W), .VERIFY_EN(1'b1)) dut_a (
    .prog_clk      (clk),
    .prog_reset_n  (rst_n),
    .start         (start_a),
    .abort         (abort_a),
    .bs            (bs_a),
    .ccff_head     (head_a),
    .ccff_shift_en (sen_a),
    .ccff_tail     (tail_a),
    .busy          (busy_a),
    .done          (done_a),
    .crc_ok        (ok_a)
  );

  // Instance B: CHAIN_LEN=16 without verify.
  logic start_b, abort_b, head_b, sen_b, tail_b, busy_b, done_b, ok_b;
  ccff_chain_loader_if #(.DATA_W(W)) bs_b ();
  ccff_chain_loader #(.CHAIN_LEN(NB), .DATA_W(W), .VERIFY_EN(1'b0)) dut_b (
    .prog_clk      (clk),
    .prog_reset_n  (rst_n),
    .start         (start_b),
    .abort         (abort_b),
    .bs            (bs_b),
    .ccff_head     (head_b),
    .ccff_shift_en (sen_b),
    .ccff_tail     (tail_b),
    .busy          (busy_b),
    .done          (done_b),
    .crc_ok        (ok_b)
  );

  // Behavioural chains: index 0 at the head, index N-1 drives the tail.
  logic [NA-1:0] chain_a = '0;
  logic [NA-1:0] nxt_a;
  logic [NA-1:0] snap_a = '0;
  logic [NB-1:0] chain_b = '0;
  int            shifts_a = 0, shifts_b = 0, base_a = 0, base_b = 0, overlap_a = 0;
  logic          flip_a = 1'b0;

  assign tail_a = chain_a[NA-1];
  assign tail_b = chain_b[NB-1];

  always @(posedge clk) begin
    nxt_a = chain_a;
    if (sen_a) begin
      nxt_a = {chain_a[NA-2:0], head_a};
      shifts_a++;
      if (shifts_a - base_a == NA) snap_a <= nxt_a;
    end
    if (flip_a) nxt_a[NA-2] = ~nxt_a[NA-2];
    chain_a <= nxt_a;
  end

  always @(posedge clk) begin
    if (sen_b) begin
      chain_b <= {chain_b[NB-2:0], head_b};
      shifts_b++;
    end
  end

  always @(negedge clk) if (sen_a && bs_a.in_ready) overlap_a++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: bitstream bits in order, first bit ends up at the tail end (index n-1).
  function automatic logic [63:0] expect_chain(input logic [7:0] w[$], input int n);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[n-1-i] = w[i/8][7-(i%8)];
    return r;
  endfunction

  task automatic rand_words(input int n, output logic [7:0] w[$]);
    w = {};
    for (int i = 0; i < n; i++) w.push_back(8'($urandom));
  endtask

  task automatic load_a(input logic [7:0] w[$], input int stall);
    int t;
    base_a = shifts_a;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    for (int k = 0; k < w.size(); k++) begin
      t = 0;
      while (!bs_a.in_ready && t < 200) begin
        if (stall > 0) begin
          bs_a.in_valid = 1'b1;
          bs_a.in_data  = ~w[k];
        end
        @(negedge clk);
        t++;
      end
      bs_a.in_valid = 1'b0;
      if (t >= 200) begin
        chk("fetch_timeout_a", 64'd0, 64'd1);
        return;
      end
      repeat (stall) @(negedge clk);
      bs_a.in_valid = 1'b1;
      bs_a.in_data  = w[k];
      @(negedge clk);
      bs_a.in_valid = 1'b0;
    end
  endtask

  task automatic load_b(input logic [7:0] w[$]);
    int t;
    base_b = shifts_b;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    for (int k = 0; k < w.size(); k++) begin
      t = 0;
      while (!bs_b.in_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) begin
        chk("fetch_timeout_b", 64'd0, 64'd1);
        return;
      end
      bs_b.in_valid = 1'b1;
      bs_b.in_data  = w[k];
      @(negedge clk);
      bs_b.in_valid = 1'b0;
    end
  endtask

  task automatic wait_done_a(input string tag);
    int t;
    t = 0;
    while (!done_a && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) chk(tag, 64'd0, 64'd1);
  endtask

  task automatic wait_shifts_a(input int n, input string tag);
    int t;
    t = 0;
    while (shifts_a - base_a < n && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) chk(tag, 64'd0, 64'd1);
  endtask

  task automatic check_load_a(input string tag, input logic [7:0] w[$], input logic exp_ok);
    chk({tag, "_done"},   64'(done_a), 64'd1);
    chk({tag, "_busy"},   64'(busy_a), 64'd0);
    chk({tag, "_crc_ok"}, 64'(ok_a), 64'(exp_ok));
    chk({tag, "_shifts"}, 64'(shifts_a - base_a), 64'(2 * NA));
    if (exp_ok) begin
      chk({tag, "_loaded"}, 64'(snap_a), expect_chain(w, NA));
      chk({tag, "_chain"},  64'(chain_a), expect_chain(w, NA));
    end
  endtask

  task automatic check_b(input string tag, input logic [7:0] w[$]);
    int t;
    t = 0;
    while (shifts_b - base_b < NB && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk({tag, "_timeout"}, 64'd0, 64'd1);
    chk({tag, "_done"},   64'(done_b), 64'd1);
    chk({tag, "_sen"},    64'(sen_b), 64'd0);
    chk({tag, "_crc_ok"}, 64'(ok_b), 64'd1);
    chk({tag, "_chain"},  64'(chain_b), expect_chain(w, NB));
    repeat (3) @(negedge clk);
    chk({tag, "_shifts"}, 64'(shifts_b - base_b), 64'(NB));
  endtask

  initial begin
    logic [7:0] wd[$];
    logic [7:0] wr[$];
    rst_n   = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; bs_a.in_valid = 1'b0; bs_a.in_data = '0;
    start_b = 1'b0; abort_b = 1'b0; bs_b.in_valid = 1'b0; bs_b.in_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(bs_a.in_ready), 64'd0);
    chk("rst_shift_en", 64'(sen_a), 64'd0);
    chk("rst_head",     64'(head_a), 64'd0);
    chk("rst_busy",     64'(busy_a), 64'd0);
    chk("rst_done",     64'(done_a), 64'd0);
    chk("rst_crc_ok",   64'(ok_a), 64'd0);
    chk("rst_done_b",   64'(done_b), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed load, back-to-back words.
    wd = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'hE0};
    load_a(wd, 0);
    wait_done_a("t1_timeout");
    check_load_a("t1", wd, 1'b1);

    // Same load with 3-cycle gaps and junk presented outside FETCH.
    load_a(wd, 3);
    wait_done_a("t2_timeout");
    check_load_a("t2", wd, 1'b1);
    chk("t2_no_shift_in_fetch", 64'(overlap_a), 64'd0);

    // Random loads.
    for (int r = 0; r < 3; r++) begin
      rand_words(5, wr);
      load_a(wr, int'($urandom_range(0, 2)));
      wait_done_a("rand_timeout");
      check_load_a("rand", wr, 1'b1);
    end

    // Corrupt one chain bit during the verify pass.
    rand_words(5, wr);
    load_a(wr, 0);
    wait_shifts_a(NA + 3, "flip_timeout");
    flip_a = 1'b1;
    @(negedge clk);
    flip_a = 1'b0;
    wait_done_a("flip_done_timeout");
    check_load_a("flip", wr, 1'b0);

    // Abort after 12 shifts, abort beats start, then a clean reload.
    rand_words(2, wr);
    load_a(wr, 0);
    wait_shifts_a(12, "abort_timeout");
    abort_a = 1'b1;
    @(negedge clk);
    chk("abort_shift_en", 64'(sen_a), 64'd0);
    chk("abort_busy",     64'(busy_a), 64'd0);
    chk("abort_done",     64'(done_a), 64'd0);
    chk("abort_in_ready", 64'(bs_a.in_ready), 64'd0);
    start_a = 1'b1;
    @(negedge clk);
    chk("abort_beats_start", 64'(busy_a), 64'd0);
    start_a = 1'b0;
    abort_a = 1'b0;
    rand_words(5, wr);
    load_a(wr, 1);
    wait_done_a("reload_timeout");
    check_load_a("reload", wr, 1'b1);

    // Start pulses while busy must not restart the load.
    rand_words(5, wr);
    load_a(wr, 0);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_shifts_a(NA + 5, "busy_start_timeout");
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done_a("busy_start_done_timeout");
    check_load_a("busy_start", wr, 1'b1);

    // Asynchronous reset in the middle of verify.
    rand_words(5, wr);
    load_a(wr, 0);
    wait_shifts_a(NA + 5, "reset_timeout");
    #2 rst_n = 1'b0;
    #1;
    chk("areset_shift_en", 64'(sen_a), 64'd0);
    chk("areset_busy",     64'(busy_a), 64'd0);
    chk("areset_head",     64'(head_a), 64'd0);
    chk("areset_done",     64'(done_a), 64'd0);
    chk("areset_crc_ok",   64'(ok_a), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_reset_busy", 64'(busy_a), 64'd0);

    // No-verify instance.
    wd = '{8'h12, 8'h34};
    load_b(wd);
    check_b("b_dir", wd);
    rand_words(2, wr);
    load_b(wr);
    check_b("b_rand", wr);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
